// File: rtl/divu_sequencer.sv
// Unsigned restoring divider that reuses one combinational 32-bit subtractor. Latency is 33 cycles
// from start to done (1 for a zero divisor). A start outside IDLE is dropped, never queued.

module subtractor (
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic [31:0] Difference,
    output logic        Borrow
);
    assign {Borrow, Difference} = {1'b0, A} - {1'b0, B};
endmodule

module divu_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] diff;
    logic             borrow;
    logic             accept;
    logic [WIDTH-1:0] r_step;
    logic [WIDTH-1:0] q_step;

    assign shifted = {r_q[WIDTH-2:0], q_q[WIDTH-1]};

    subtractor u_sub (
        .A          (shifted),
        .B          (d_q),
        .Difference (diff),
        .Borrow     (borrow)
    );

    // r_q[MSB] is the bit shifted out of the W-bit window: the true shifted
    // remainder then exceeds any divisor, so the subtraction must be taken.
    assign accept = r_q[WIDTH-1] | ~borrow;
    assign r_step = accept ? diff : shifted;
    assign q_step = {q_q[WIDTH-2:0], accept};

    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        q_d     = q_q;
        d_d     = d_q;
        cnt_d   = cnt_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (divisor == '0) begin
                        state_d = DONE;
                        quot_d  = '1;
                        rem_d   = dividend;
                        dbz_d   = 1'b1;
                    end else begin
                        state_d = RUN;
                        r_d     = '0;
                        q_d     = dividend;
                        d_d     = divisor;
                        cnt_d   = '0;
                    end
                end
            end
            RUN: begin
                r_d   = r_step;
                q_d   = q_step;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_ITER) begin
                    state_d = DONE;
                    quot_d  = q_step;
                    rem_d   = r_step;
                    dbz_d   = 1'b0;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            r_q     <= '0;
            q_q     <= '0;
            d_q     <= '0;
            cnt_q   <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            q_q     <= q_d;
            d_q     <= d_d;
            cnt_q   <= cnt_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    assign busy        = (state_q == RUN) || (state_q == DONE);
    assign done        = (state_q == DONE);
    assign quotient    = quot_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;
endmodule

// File: doc/divu_sequencer.md
# divu_sequencer

Multi-cycle unsigned divider controller that time-shares a single instance of the team's 32-bit `subtractor` (A, B → Difference, Borrow) to compute quotient and remainder by restoring shift-subtract division. It owns the partial-remainder/quotient registers, drives the subtractor operands each cycle, and decides from `Borrow` whether to commit the trial difference. It sits beside the ALU as the divide unit, with a start/done handshake toward the control FSM.

## Interface
- `WIDTH`, 32, operand/result width; the instantiated `subtractor` is fixed at 32 bits, so only 32 is supported.
- `clk`  input  1  single clock; all state changes on rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `start`  input  1  request; sampled only in IDLE.
- `dividend`  input  WIDTH  unsigned dividend, sampled with `start`.
- `divisor`  input  WIDTH  unsigned divisor, sampled with `start`.
- `busy`  output  1  high in RUN and DONE.
- `done`  output  1  one-cycle pulse; results valid from this cycle.
- `quotient`  output  WIDTH  registered result.
- `remainder`  output  WIDTH  registered result.
- `div_by_zero`  output  1  registered flag for the latest operation.

## Operation
- States: IDLE, RUN, DONE. Encoding is free.
- IDLE: `start`=1 latches operands. Divisor==0 → DONE directly. Otherwise → RUN with R=0, Q=dividend, D=divisor, iteration count=0.
- RUN, one iteration per cycle, WIDTH iterations:
  - shifted remainder S = {R[W-2:0], Q[W-1]}; overflow bit m = R[W-1].
  - subtractor inputs: A=S, B=D.
  - accept = m | ~Borrow.
  - if accept: R ← Difference (mod 2^W), Q ← {Q[W-2:0],1}.
  - else: R ← S, Q ← {Q[W-2:0],0}.
  - After iteration WIDTH-1 → DONE.
  - The m term covers divisors ≥ 2^(W-1), where S needs W+1 bits. Without it, results are wrong.
- Entering DONE:
  - Normal case: `quotient`←Q, `remainder`←R, `div_by_zero`←0.
  - Divide by zero: `quotient`←all ones, `remainder`←dividend, `div_by_zero`←1.
- DONE lasts exactly one cycle with `done`=1, then → IDLE.
- Outputs `quotient`, `remainder` and `div_by_zero` hold their value until the next entry into DONE. They do not change during RUN.
- `start` in RUN or DONE is ignored. It is not queued.
- Reset values: state IDLE; `busy`, `done`, `div_by_zero` = 0; `quotient`, `remainder` = 0; internal R, Q, D and count = 0.
- Reset asserted mid-RUN aborts the operation. All outputs are 0 after that edge, and no `done` pulse is issued.
- Reset wins over a simultaneous `start`.

## Timing
- `start` sampled high at edge k, nonzero divisor:
  - `busy`=1 after edge k.
  - Iterations occur at edges k+1 … k+WIDTH.
  - DONE (`done`=1, results valid) holds after edge k+WIDTH, for one cycle.
  - IDLE after edge k+WIDTH+1.
  - Latency is WIDTH+1 = 33 cycles from the start edge to the `done` cycle.
- Divide by zero: DONE after edge k, so `done` goes high in the cycle after the start edge (latency 1).
- Back-to-back operation: the earliest next `start` is sampled at edge k+WIDTH+1, when the state is IDLE again.
- The subtractor is purely combinational. Its A/B inputs come from registers, and Difference/Borrow are consumed at the same edge.

## Test plan
- 7 ÷ 3: `done` 33 cycles after start; `quotient`=2, `remainder`=1, `div_by_zero`=0; `busy` high for exactly 33 cycles.
- 5 ÷ 9: `quotient`=0, `remainder`=5.
- 0xFFFFFFFF ÷ 0x80000001: `quotient`=1, `remainder`=0x7FFFFFFE. Exercises the overflow-bit accept path. Also 0xFFFFFFFF ÷ 1 → `quotient`=0xFFFFFFFF, `remainder`=0.
- 100 ÷ 0: `done` one cycle after start; `quotient`=0xFFFFFFFF, `remainder`=100, `div_by_zero`=1. A following 9 ÷ 3 clears the flag and gives `quotient`=3, `remainder`=0.
- Start 1000 ÷ 7, pulse `start` with 8 ÷ 2 during RUN: the second request is ignored, and the result is `quotient`=142, `remainder`=6 with a single `done` pulse.
- Assert `rst` for one cycle at iteration 10 of 1000 ÷ 7: on the next cycle `busy`=0, outputs are 0, no `done` follows, and a subsequent 7 ÷ 3 completes normally.
